imem_loader: RTL and testbench

Instruction-side front end for the single-cycle RISC-V core. It owns the instruction memory and accepts a program as a byte stream over a valid/ready port, packing the bytes little-endian into words. It holds the core in reset until the load completes, then answers the core's fetch address with the instruction word in the same cycle. It sits directly upstream of the core: it drives the core's `Instr` and reset inputs and consumes its `PC`.

---
 rtl/imem_pkg.sv | 23 ++
 rtl/imem_loader_byte_packer.sv | 42 ++++
 rtl/imem_loader.sv | 135 +++++++++++++
 tb/tb_imem_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// ============================================================================
// Module      : imem_pkg
// Description : Shared types and constants for the instruction-side front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } imem_state_t;

    localparam logic [31:0] IMEM_BASE    = 32'h0040_0000;
    localparam logic [31:0] RV_NOP       = 32'h0000_0013;
    // The core's PC register resets to the first word of the text segment.
    localparam logic [31:0] RESET_VECTOR = IMEM_BASE;

endpackage

`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
// ============================================================================
// Module      : byte_packer
// Description : Assembles a little-endian 32-bit word from four pushed bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  r_lane;
    logic [23:0] r_asm;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_lane <= 2'd0;
            r_asm  <= 24'd0;
        end else if (push) begin
            r_lane <= r_lane + 2'd1;
            case (r_lane)
                2'd0:    r_asm[7:0]   <= data;
                2'd1:    r_asm[15:8]  <= data;
                2'd2:    r_asm[23:16] <= data;
                default: r_asm        <= r_asm;
            endcase
        end
    end

    // The fourth byte bypasses the register straight into the upper lane.
    assign word       = {data, r_asm};
    assign word_valid = push && (r_lane == 2'd3);

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Byte-stream program loader and zero-latency instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
    import imem_pkg::*;
#(
    parameter int          DEPTH = 256,
    parameter logic [31:0] BASE  = IMEM_BASE,
    parameter logic [31:0] NOP   = RV_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic [15:0] load_words,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        load_done,
    output logic        load_err,
    output logic        cpu_rst,
    input  logic [31:0] pc,
    output logic [31:0] instr,
    output logic        fetch_fault
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    imem_state_t r_state;
    imem_state_t w_state_next;

    logic [CW-1:0] r_word_cnt;
    logic [CW-1:0] r_wr_idx;
    logic [CW-1:0] r_loaded;
    logic          r_load_err;
    logic [31:0]   r_mem [DEPTH];

    logic          w_legal;
    logic          w_accept;
    logic          w_reject;
    logic          w_push;
    logic [31:0]   w_word;
    logic          w_word_valid;
    logic          w_last;
    logic [31:0]   w_off;
    logic [31:0]   w_idx;
    logic          w_bad_addr;
    logic          w_hit;

    assign w_legal  = (load_words != 16'd0) && ({16'd0, load_words} <= 32'(DEPTH));
    assign w_accept = load_start && w_legal  && (r_state != LOAD);
    assign w_reject = load_start && !w_legal && (r_state != LOAD);
    assign w_push   = byte_valid && byte_ready;
    assign w_last   = w_word_valid && ((r_wr_idx + CW'(1)) == r_word_cnt);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_accept),
        .push       (w_push),
        .data       (byte_data),
        .word       (w_word),
        .word_valid (w_word_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_word_cnt <= '0;
            r_wr_idx   <= '0;
            r_loaded   <= '0;
            r_load_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_load_err <= 1'b0;
                r_word_cnt <= CW'(load_words);
                r_wr_idx   <= '0;
                r_loaded   <= '0;
            end else if (w_reject) begin
                r_load_err <= 1'b1;
            end
            if (w_word_valid) begin
                r_wr_idx <= r_wr_idx + CW'(1);
                r_loaded <= r_loaded + CW'(1);
            end
        end
    end

    // Memory is never cleared; r_loaded masks stale contents on fetch.
    always_ff @(posedge clk) begin
        if (!rst && w_word_valid) begin
            r_mem[r_wr_idx[AW-1:0]] <= w_word;
        end
    end

    always_comb begin
        w_state_next = r_state;
        byte_ready   = 1'b0;
        cpu_rst      = 1'b1;
        load_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_next = LOAD;
            end
            LOAD: begin
                byte_ready = 1'b1;
                if (w_last) w_state_next = RUN;
            end
            RUN: begin
                cpu_rst   = 1'b0;
                load_done = 1'b1;
                if (w_accept) w_state_next = LOAD;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign load_err = r_load_err;

    assign w_off      = pc - BASE;
    assign w_idx      = w_off >> 2;
    assign w_bad_addr = (pc[1:0] != 2'b00) || (pc < BASE) || (w_idx >= 32'(DEPTH));
    assign w_hit      = (r_state == RUN) && !w_bad_addr && (w_idx < 32'(r_loaded));

    assign fetch_fault = (r_state == RUN) && w_bad_addr;
    assign instr       = w_hit ? r_mem[w_idx[AW-1:0]] : NOP;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed, table-driven bench for the instruction loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic [15:0] load_words = 16'd0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic        load_done;
    logic        load_err;
    logic        cpu_rst;
    logic [31:0] pc = BASE;
    logic [31:0] instr;
    logic        fetch_fault;

    int n_checks = 0;
    int n_fail   = 0;

    imem_loader #(.DEPTH(DEPTH), .BASE(BASE), .NOP(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_words  (load_words),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .load_done   (load_done),
        .load_err    (load_err),
        .cpu_rst     (cpu_rst),
        .pc          (pc),
        .instr       (instr),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_vec_t;

    fetch_vec_t vecs [8];
    logic [7:0] prog2 [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [15:0] n);
        load_start = 1'b1;
        load_words = n;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (!byte_ready && t < 20) begin
            tick();
            t++;
        end
        chk("byte_ready_wait", {31'd0, byte_ready}, 32'd1);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic run_fetch_table(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            pc = vecs[i].pc;
            #1;
            chk($sformatf("%s_instr[%0d]", tag, i), instr, vecs[i].instr);
            chk($sformatf("%s_fault[%0d]", tag, i), {31'd0, fetch_fault}, {31'd0, vecs[i].fault});
        end
        pc = BASE;
        #1;
    endtask

    initial begin
        vecs[0] = '{BASE,                  32'h00A0_0513, 1'b0};
        vecs[1] = '{BASE + 32'd4,          32'h0010_0593, 1'b0};
        vecs[2] = '{BASE + 32'd8,          NOP,           1'b0};
        vecs[3] = '{BASE + 32'd1020,       NOP,           1'b0};
        vecs[4] = '{32'h0040_0002,         NOP,           1'b1};
        vecs[5] = '{32'h003F_FFFC,         NOP,           1'b1};
        vecs[6] = '{BASE + 32'd1024,       NOP,           1'b1};
        vecs[7] = '{32'hFFFF_FFFC,         NOP,           1'b1};
        prog2 = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};

        // Reset state
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_load_done",  {31'd0, load_done},  32'd0);
        chk("rst_load_err",   {31'd0, load_err},   32'd0);
        chk("rst_cpu_rst",    {31'd0, cpu_rst},    32'd1);
        chk("rst_instr",      instr,               NOP);
        pc = BASE + 32'd2;
        #1;
        chk("idle_fault_masked", {31'd0, fetch_fault}, 32'd0);
        pc = BASE;

        // Bytes offered in IDLE are refused
        byte_valid = 1'b1;
        byte_data  = 8'hEE;
        #1;
        chk("idle_byte_ready", {31'd0, byte_ready}, 32'd0);
        byte_valid = 1'b0;

        // Plain 2-word load
        start_load(16'd2);
        chk("load_byte_ready", {31'd0, byte_ready}, 32'd1);
        chk("load_cpu_rst",    {31'd0, cpu_rst},    32'd1);
        for (int i = 0; i < 8; i++) send_byte(prog2[i], 0);
        chk("run_cpu_rst",    {31'd0, cpu_rst},    32'd0);
        chk("run_load_done",  {31'd0, load_done},  32'd1);
        chk("run_byte_ready", {31'd0, byte_ready}, 32'd0);
        run_fetch_table(8, "plain");

        // Illegal counts from IDLE
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start_load(16'd0);
        chk("err0_load_err", {31'd0, load_err},   32'd1);
        chk("err0_cpu_rst",  {31'd0, cpu_rst},    32'd1);
        chk("err0_ready",    {31'd0, byte_ready}, 32'd0);
        start_load(16'(DEPTH + 1));
        chk("errD_load_err", {31'd0, load_err},   32'd1);
        chk("errD_ready",    {31'd0, byte_ready}, 32'd0);
        chk("errD_done",     {31'd0, load_done},  32'd0);

        // Legal start clears the error; gapped byte stream
        start_load(16'd2);
        chk("clr_load_err", {31'd0, load_err},   32'd0);
        chk("clr_ready",    {31'd0, byte_ready}, 32'd1);
        for (int i = 0; i < 7; i++) send_byte(prog2[i], 3);
        chk("gap_pre_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        send_byte(prog2[7], 3);
        chk("gap_post_cpu_rst", {31'd0, cpu_rst},   32'd0);
        chk("gap_post_done",    {31'd0, load_done}, 32'd1);
        run_fetch_table(8, "gapped");

        // Illegal count in RUN: error set, core keeps running
        start_load(16'd0);
        chk("runerr_load_err", {31'd0, load_err},  32'd1);
        chk("runerr_done",     {31'd0, load_done}, 32'd1);
        chk("runerr_cpu_rst",  {31'd0, cpu_rst},   32'd0);

        // Reset in the middle of a load
        start_load(16'd2);
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ready",   {31'd0, byte_ready}, 32'd0);
        chk("mid_rst_cpu_rst", {31'd0, cpu_rst},    32'd1);
        chk("mid_rst_instr",   instr,               NOP);
        start_load(16'd1);
        send_byte(8'hB3, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("fresh_instr0", instr, 32'h0000_00B3);
        pc = BASE + 32'd4;
        #1;
        chk("fresh_instr1_masked", instr, NOP);
        pc = BASE;
        #1;

        // Reload from RUN
        start_load(16'd1);
        chk("reload_cpu_rst", {31'd0, cpu_rst},   32'd1);
        chk("reload_done",    {31'd0, load_done}, 32'd0);
        chk("reload_instr",   instr,              NOP);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        chk("reload_partial_instr", instr, NOP);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        chk("reload_final_instr", instr, 32'h4433_2211);
        chk("reload_final_done",  {31'd0, load_done}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
